// File: rtl/sram_arbiter.sv
// Two-client round-robin arbiter in front of a single-port sram_core.
// One access per cycle; registered core-side outputs and read-response tracking.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_a_valid,
    output logic                  req_a_ready,
    input  logic                  req_a_we,
    input  logic [ADDR_WIDTH-1:0] req_a_addr,
    input  logic [DATA_WIDTH-1:0] req_a_wdata,
    output logic                  rsp_a_valid,
    output logic [DATA_WIDTH-1:0] rsp_a_rdata,

    input  logic                  req_b_valid,
    output logic                  req_b_ready,
    input  logic                  req_b_we,
    input  logic [ADDR_WIDTH-1:0] req_b_addr,
    input  logic [DATA_WIDTH-1:0] req_b_wdata,
    output logic                  rsp_b_valid,
    output logic [DATA_WIDTH-1:0] rsp_b_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t r_last_grant;
    grant_t r_owner;
    logic   w_grant_a;
    logic   w_grant_b;

    // Under contention the client that did not win last time gets the slot.
    always_comb begin
        w_grant_a = req_a_valid && (!req_b_valid || (r_last_grant == GRANT_B));
        w_grant_b = req_b_valid && (!req_a_valid || (r_last_grant == GRANT_A));
    end

    assign req_a_ready = w_grant_a && !rst;
    assign req_b_ready = w_grant_b && !rst;

    assign rsp_a_rdata = mem_rdata;
    assign rsp_b_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_B;
            r_owner      <= GRANT_A;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            rsp_a_valid  <= 1'b0;
            rsp_b_valid  <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            if (w_grant_a) begin
                r_last_grant <= GRANT_A;
                r_owner      <= GRANT_A;
                mem_addr     <= req_a_addr;
                mem_wdata    <= req_a_wdata;
                mem_write_en <= req_a_we;
                mem_read_en  <= !req_a_we;
            end else if (w_grant_b) begin
                r_last_grant <= GRANT_B;
                r_owner      <= GRANT_B;
                mem_addr     <= req_b_addr;
                mem_wdata    <= req_b_wdata;
                mem_write_en <= req_b_we;
                mem_read_en  <= !req_b_we;
            end
            // The core returns read data one cycle after mem_read_en; flag it to the issuing client.
            rsp_a_valid <= mem_read_en && (r_owner == GRANT_A);
            rsp_b_valid <= mem_read_en && (r_owner == GRANT_B);
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed-vector bench for sram_arbiter with a behavioural single-port SRAM
// (registered read, one-cycle latency) standing in for sram_core.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a_valid = 1'b0, req_a_we = 1'b0;
    logic [7:0]  req_a_addr = '0;
    logic [31:0] req_a_wdata = '0;
    logic        req_b_valid = 1'b0, req_b_we = 1'b0;
    logic [7:0]  req_b_addr = '0;
    logic [31:0] req_b_wdata = '0;
    logic        req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid;
    logic [31:0] rsp_a_rdata, rsp_b_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write_en, mem_read_en;
    logic [31:0] mem_rdata;
    logic [31:0] sram [0:255];

    int total = 0;
    int bad   = 0;

    sram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
        .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata),
        .rsp_a_valid(rsp_a_valid), .rsp_a_rdata(rsp_a_rdata),
        .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
        .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata),
        .rsp_b_valid(rsp_b_valid), .rsp_b_rdata(rsp_b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) sram[mem_addr] <= mem_wdata;
        if (mem_read_en)  mem_rdata <= sram[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_a_valid = 1'b1;
        req_b_valid = 1'b1;
        step();
        step();
        total++;
        if ({req_a_ready, req_b_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready got=%b exp=00", {req_a_ready, req_b_ready});
        end
        total++;
        if ({mem_write_en, mem_read_en, rsp_a_valid, rsp_b_valid} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000",
                            {mem_write_en, mem_read_en, rsp_a_valid, rsp_b_valid});
        end
        total++;
        if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h exp=00/00000000", mem_addr, mem_wdata);
        end
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_then_read();
        req_a_valid = 1'b1; req_a_we = 1'b1; req_a_addr = 8'h10; req_a_wdata = 32'hDEADBEEF;
        #1;
        total++;
        if (req_a_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", req_a_ready); end
        step();
        total++;
        if ({mem_write_en, mem_read_en, mem_addr, mem_wdata} !== {2'b10, 8'h10, 32'hDEADBEEF}) begin
            bad++; $display("FAIL wr_issue got=%b%b %h %h exp=10 10 deadbeef",
                            mem_write_en, mem_read_en, mem_addr, mem_wdata);
        end
        req_a_we = 1'b0;
        step();
        total++;
        if ({mem_write_en, mem_read_en, mem_addr} !== {2'b01, 8'h10}) begin
            bad++; $display("FAIL rd_issue got=%b%b %h exp=01 10", mem_write_en, mem_read_en, mem_addr);
        end
        idle_inputs();
        step();
        total++;
        if ({rsp_a_valid, rsp_b_valid, rsp_a_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++; $display("FAIL rd_rsp got=%b%b %h exp=10 deadbeef", rsp_a_valid, rsp_b_valid, rsp_a_rdata);
        end
        step();
        total++;
        if ({rsp_a_valid, rsp_b_valid, mem_write_en, mem_read_en} !== 4'b0000) begin
            bad++; $display("FAIL rd_after got=%b exp=0000",
                            {rsp_a_valid, rsp_b_valid, mem_write_en, mem_read_en});
        end
    endtask

    task automatic test_cross_client_raw();
        req_b_valid = 1'b1; req_b_we = 1'b1; req_b_addr = 8'h20; req_b_wdata = 32'h00001234;
        #1;
        total++;
        if (req_b_ready !== 1'b1) begin bad++; $display("FAIL raw_b_ready got=%b exp=1", req_b_ready); end
        step();
        req_b_valid = 1'b0;
        req_a_valid = 1'b1; req_a_we = 1'b0; req_a_addr = 8'h20;
        #1;
        total++;
        if (req_a_ready !== 1'b1) begin bad++; $display("FAIL raw_a_ready got=%b exp=1", req_a_ready); end
        step();
        idle_inputs();
        step();
        total++;
        if ({rsp_a_valid, rsp_b_valid, rsp_a_rdata} !== {2'b10, 32'h00001234}) begin
            bad++; $display("FAIL raw_rsp got=%b%b %h exp=10 00001234", rsp_a_valid, rsp_b_valid, rsp_a_rdata);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_data;
        req_a_valid = 1'b1; req_a_we = 1'b1; req_a_addr = 8'h01; req_a_wdata = 32'hAAAA0001;
        step();
        req_a_valid = 1'b0;
        req_b_valid = 1'b1; req_b_we = 1'b1; req_b_addr = 8'h02; req_b_wdata = 32'hBBBB0002;
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a_valid = 1'b1; req_a_we = 1'b0; req_a_addr = 8'h01;
        req_b_valid = 1'b1; req_b_we = 1'b0; req_b_addr = 8'h02;
        for (int k = 0; k < 6; k++) begin
            if (k >= 1) begin
                total++;
                if ({mem_read_en, mem_addr} !== {1'b1, ((k - 1) % 2 == 0) ? 8'h01 : 8'h02}) begin
                    bad++; $display("FAIL cont_issue k=%0d got=%b %h", k, mem_read_en, mem_addr);
                end
            end
            if (k >= 2) begin
                exp_data = ((k - 2) % 2 == 0) ? 32'hAAAA0001 : 32'hBBBB0002;
                total++;
                if ({rsp_a_valid, rsp_b_valid} !== (((k - 2) % 2 == 0) ? 2'b10 : 2'b01)
                    || rsp_a_rdata !== exp_data) begin
                    bad++; $display("FAIL cont_rsp k=%0d got=%b%b %h exp_data=%h",
                                    k, rsp_a_valid, rsp_b_valid, rsp_a_rdata, exp_data);
                end
            end
            #1;
            total++;
            if ({req_a_ready, req_b_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL cont_grant k=%0d got=%b%b", k, req_a_ready, req_b_ready);
            end
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        req_b_valid = 1'b1; req_b_we = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k >= 1) begin
                total++;
                if ({mem_write_en, mem_addr, mem_wdata} !== {1'b1, 8'h30 + 8'(k - 1), 32'h5000 + 32'(k - 1)}) begin
                    bad++; $display("FAIL b2b_issue k=%0d got=%b %h %h", k, mem_write_en, mem_addr, mem_wdata);
                end
            end
            req_b_addr = 8'h30 + 8'(k);
            req_b_wdata = 32'h5000 + 32'(k);
            #1;
            total++;
            if (req_b_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, req_b_ready); end
            step();
        end
        idle_inputs();
        total++;
        if ({mem_write_en, mem_addr, mem_wdata} !== {1'b1, 8'h34, 32'h5004}) begin
            bad++; $display("FAIL b2b_last got=%b %h %h exp=1 34 00005004", mem_write_en, mem_addr, mem_wdata);
        end
        step();
        total++;
        if ({mem_write_en, mem_read_en, mem_addr} !== {2'b00, 8'h34}) begin
            bad++; $display("FAIL b2b_hold got=%b%b %h exp=00 34", mem_write_en, mem_read_en, mem_addr);
        end
    endtask

    task automatic test_reset_midflight();
        req_a_valid = 1'b1; req_a_we = 1'b0; req_a_addr = 8'h10;
        step();
        rst = 1'b1;
        req_b_valid = 1'b1; req_b_we = 1'b0; req_b_addr = 8'h02;
        #1;
        total++;
        if ({req_a_ready, req_b_ready} !== 2'b00) begin
            bad++; $display("FAIL rstmid_ready got=%b%b exp=00", req_a_ready, req_b_ready);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if ({rsp_a_valid, rsp_b_valid, mem_write_en, mem_read_en} !== 4'b0000 || mem_addr !== 8'h00) begin
                bad++; $display("FAIL rstmid_drop k=%0d got=%b %h exp=0000 00",
                                k, {rsp_a_valid, rsp_b_valid, mem_write_en, mem_read_en}, mem_addr);
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if ({req_a_ready, req_b_ready} !== 2'b10) begin
            bad++; $display("FAIL rstmid_first got=%b%b exp=10", req_a_ready, req_b_ready);
        end
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_held_loser();
        req_b_valid = 1'b1; req_b_we = 1'b0; req_b_addr = 8'h02;
        step();
        req_a_valid = 1'b1; req_a_we = 1'b0; req_a_addr = 8'h01;
        req_b_we = 1'b1; req_b_addr = 8'h40; req_b_wdata = 32'h00000055;
        #1;
        total++;
        if ({req_a_ready, req_b_ready} !== 2'b10) begin
            bad++; $display("FAIL hold_first got=%b%b exp=10", req_a_ready, req_b_ready);
        end
        step();
        req_a_addr = 8'h03;
        #1;
        total++;
        if ({req_a_ready, req_b_ready} !== 2'b01 || {mem_read_en, mem_addr} !== {1'b1, 8'h01}) begin
            bad++; $display("FAIL hold_second got=%b%b %b %h exp=01 1 01",
                            req_a_ready, req_b_ready, mem_read_en, mem_addr);
        end
        step();
        idle_inputs();
        total++;
        if ({mem_write_en, mem_read_en, mem_addr, mem_wdata} !== {2'b10, 8'h40, 32'h00000055}) begin
            bad++; $display("FAIL hold_issue got=%b%b %h %h exp=10 40 00000055",
                            mem_write_en, mem_read_en, mem_addr, mem_wdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_cross_client_raw();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_held_loser();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
